// File: rtl/spk_pkg.sv
// spk_pkg: shared state encoding and sizing helpers for the spike train generator
package spk_pkg;
  typedef enum logic [1:0] {SPK_IDLE = 2'd0, SPK_HIGH = 2'd1, SPK_GAP = 2'd2} spk_state_t;
  function automatic int spk_clog2(input int n);
    int r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int spk_sat(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/spike_chan.sv
// spike_chan: one channel - synchroniser, edge detect, pending queue, spike FSM, watchdog
module spike_chan
  import spk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PW_CYC      = 2,
  parameter int GAP_CYC     = 2,
  parameter int CNT_W       = 4,
  parameter int WD_CYC      = 256
) (
  input  logic sysClk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic trig,
  output logic spike,
  output logic busy,
  output logic overflow,
  output logic stall
);
  localparam int TW = spk_clog2(PW_CYC > GAP_CYC ? PW_CYC : GAP_CYC);
  localparam int WW = spk_clog2(WD_CYC);
  localparam logic [CNT_W-1:0] SAT = CNT_W'(spk_sat(CNT_W));
  logic [SYNC_STAGES-1:0] sync;
  logic sync_d, edge_c, edge_q, start, dec, inc;
  spk_state_t state;
  logic [TW-1:0] tmr;
  logic [CNT_W-1:0] pend;
  logic [WW-1:0] wd;
  assign edge_c = sync[SYNC_STAGES-1] & ~sync_d;
  // a clr cycle flushes the queue, so it must not launch a spike either
  assign start = state == SPK_IDLE & en & ~clr & (edge_q | pend != '0);
  assign dec = start & pend != '0;
  assign inc = edge_q & ~(start & pend == '0);
  assign busy = state != SPK_IDLE | pend != '0;
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      sync_d <= 1'b0;
      edge_q <= 1'b0;
      state <= SPK_IDLE;
      tmr <= '0;
      spike <= 1'b0;
      pend <= '0;
      overflow <= 1'b0;
      wd <= '0;
      stall <= 1'b0;
    end else begin
      sync <= SYNC_STAGES'({sync, trig});
      sync_d <= sync[SYNC_STAGES-1];
      edge_q <= edge_c;
      if (state == SPK_IDLE) begin
        if (start) begin
          state <= SPK_HIGH;
          tmr <= TW'(PW_CYC - 1);
          spike <= 1'b1;
        end
      end else if (tmr != '0) tmr <= tmr - 1'b1;
      else if (state == SPK_HIGH) begin
        state <= SPK_GAP;
        tmr <= TW'(GAP_CYC - 1);
        spike <= 1'b0;
      end else state <= SPK_IDLE;
      if (clr) begin
        pend <= '0;
        overflow <= 1'b0;
      end else if (inc & ~dec & pend == SAT) overflow <= 1'b1;
      else pend <= pend + CNT_W'(inc) - CNT_W'(dec);
      if (edge_c) begin
        wd <= '0;
        stall <= 1'b0;
      end else if (!en) wd <= '0;
      else if (wd != WW'(WD_CYC - 1)) begin
        wd <= wd + 1'b1;
        stall <= stall | (wd == WW'(WD_CYC - 2));
      end
    end
  end
endmodule

// File: rtl/spike_train_gen_mc.sv
// spike_train_gen_mc: N independent edge-to-spike channels sharing enable and flush
module spike_train_gen_mc
  import spk_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PW_CYC      = 2,
  parameter int GAP_CYC     = 2,
  parameter int CNT_W       = 4,
  parameter int WD_CYC      = 256
) (
  input  logic            sysClk,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  input  logic [N_CH-1:0] trig_in,
  output logic [N_CH-1:0] spike_out,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] overflow,
  output logic [N_CH-1:0] stall
);
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    spike_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .PW_CYC(PW_CYC),
      .GAP_CYC(GAP_CYC),
      .CNT_W(CNT_W),
      .WD_CYC(WD_CYC)
    ) u_chan (
      .sysClk(sysClk),
      .reset(reset),
      .en(en),
      .clr(clr),
      .trig(trig_in[g]),
      .spike(spike_out[g]),
      .busy(busy[g]),
      .overflow(overflow[g]),
      .stall(stall[g])
    );
  end
endmodule

// File: tb/tb_spike_train_gen_mc.sv
// tb_spike_train_gen_mc: random and directed stimulus checked against a cycle-level reference model
module tb_spike_train_gen_mc;
  localparam int N = 4, S = 2, PW = 2, GAP = 2, CW = 4, WD = 16, MAXP = (1 << CW) - 1;
  logic sysClk = 1'b0, reset = 1'b1, en = 1'b0, clr = 1'b0;
  logic [N-1:0] trig_in = '0, tv = '0;
  logic [N-1:0] spike_out, busy, overflow, stall;
  int checks = 0, failures = 0;
  int hist[N][S+3];
  int ph[N], pend[N], wdc[N];
  bit ovf[N], stl[N];
  spike_train_gen_mc #(
    .N_CH(N), .SYNC_STAGES(S), .PW_CYC(PW), .GAP_CYC(GAP), .CNT_W(CW), .WD_CYC(WD)
  ) dut (
    .sysClk(sysClk), .reset(reset), .en(en), .clr(clr), .trig_in(trig_in),
    .spike_out(spike_out), .busy(busy), .overflow(overflow), .stall(stall)
  );
  always #5 sysClk = ~sysClk;
  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      for (int k = 0; k < S + 3; k++) hist[c][k] = 0;
      ph[c] = 0; pend[c] = 0; wdc[c] = 0; ovf[c] = 0; stl[c] = 0;
    end
  endtask
  // a trigger sampled at posedge n is seen by the FSM at posedge n+S+1 and by the watchdog at n+S
  task automatic model_step(input logic [N-1:0] t, input logic e, input logic c_in);
    bit ef, ew, st, used;
    for (int c = 0; c < N; c++) begin
      for (int k = S + 2; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = int'(t[c]);
      ef = hist[c][S+1] == 1 && hist[c][S+2] == 0;
      ew = hist[c][S] == 1 && hist[c][S+1] == 0;
      st = ph[c] == 0 && e && !c_in && (ef || pend[c] > 0);
      used = st && pend[c] == 0;
      if (ph[c] != 0) ph[c] = (ph[c] == PW + GAP) ? 0 : ph[c] + 1;
      else if (st) ph[c] = 1;
      if (c_in) begin
        pend[c] = 0; ovf[c] = 0;
      end else begin
        if (st && pend[c] > 0) pend[c]--;
        if (ef && !used) begin
          if (pend[c] == MAXP) ovf[c] = 1;
          else pend[c]++;
        end
      end
      if (ew) begin
        wdc[c] = 0; stl[c] = 0;
      end else if (!e) wdc[c] = 0;
      else begin
        if (wdc[c] < WD - 1) wdc[c]++;
        if (wdc[c] == WD - 1) stl[c] = 1;
      end
    end
  endtask
  task automatic compare_all(input string tag);
    logic [N-1:0] es, eb, eo, ew;
    for (int c = 0; c < N; c++) begin
      es[c] = ph[c] >= 1 && ph[c] <= PW;
      eb[c] = ph[c] != 0 || pend[c] != 0;
      eo[c] = ovf[c];
      ew[c] = stl[c];
    end
    check({tag, ".spike"}, spike_out, es);
    check({tag, ".busy"}, busy, eb);
    check({tag, ".overflow"}, overflow, eo);
    check({tag, ".stall"}, stall, ew);
  endtask
  task automatic cyc(input string tag, input logic e, input logic c_in);
    trig_in = tv; en = e; clr = c_in;
    @(posedge sysClk);
    model_step(tv, e, c_in);
    #1 compare_all(tag);
  endtask
  initial begin
    int p;
    model_reset();
    repeat (2) @(posedge sysClk);
    #1 reset = 1'b0;
    compare_all("reset");
    tv[0] = 1'b1;
    repeat (12) cyc("single", 1, 0);
    for (int i = 0; i < 5; i++) begin
      tv[1] = 1'b1; cyc("burst", 1, 0);
      tv[1] = 1'b0; cyc("burst", 1, 0);
    end
    repeat (30) cyc("burst_drain", 1, 0);
    tv[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tv[2] = 1'b1; cyc("sat_fill", 0, 0);
      tv[2] = 1'b0; cyc("sat_fill", 0, 0);
    end
    repeat (90) cyc("sat_drain", 1, 0);
    cyc("sat_clr", 1, 1);
    cyc("sat_clr_after", 1, 0);
    tv[0] = 1'b1; cyc("deq_edge", 0, 0);
    tv[0] = 1'b0; repeat (6) cyc("deq_edge", 0, 0);
    tv[0] = 1'b1; cyc("deq_edge", 0, 0);
    tv[0] = 1'b0; cyc("deq_edge", 0, 0);
    cyc("deq_edge", 0, 0);
    repeat (15) cyc("deq_edge", 1, 0);
    tv[3] = 1'b1; cyc("clr_edge", 1, 0);
    tv[3] = 1'b0; cyc("clr_edge", 1, 0);
    cyc("clr_edge", 1, 0);
    cyc("clr_edge", 1, 1);
    repeat (10) cyc("clr_edge", 1, 0);
    repeat (20) cyc("wd_idle", 1, 0);
    tv[1] = 1'b1; repeat (4) cyc("wd_edge", 1, 0);
    repeat (20) cyc("wd_off", 0, 0);
    tv = '0; repeat (8) cyc("pre_rst", 1, 0);
    tv = '1; cyc("rst_mid", 1, 0);
    tv = '0; repeat (3) cyc("rst_mid", 1, 0);
    #2 reset = 1'b1;
    model_reset();
    #1 compare_all("async_rst");
    @(posedge sysClk);
    #1 reset = 1'b0;
    repeat (10) cyc("post_rst", 0, 0);
    for (int seg = 0; seg < 4; seg++) begin
      p = (seg == 0) ? 2 : (seg == 1) ? 3 : (seg == 2) ? 5 : 9;
      repeat (500) begin
        for (int c = 0; c < N; c++) if ($urandom % p == 0) tv[c] = ~tv[c];
        cyc("random", ($urandom % 8) != 0, ($urandom % 64) == 0);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
